mem_access: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; consumes the registered EX/MEM latch outputs and feeds the MEM/WB latch.
- Performs loads and stores over a request/acknowledge data bus with variable latency.
- Raises a stall request while a transfer is outstanding.
- Passes non-memory results straight through.

---
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MIPS MEM stage: loads/stores over a variable-latency req/ack data bus, stalls the pipe while a transfer is open.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without touching the bus.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_q;
    logic              abort_q;

    logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic        is_mem, misalign, start;
    logic [1:0]  a;
    logic [3:0]  sel;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        req;

    assign a = mem_mem_addr[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (mem_aluop)
            OP_LB:   begin is_load = 1'b1;  is_byte = 1'b1; is_signed = 1'b1; end
            OP_LH:   begin is_load = 1'b1;  is_half = 1'b1; is_signed = 1'b1; end
            OP_LW:   begin is_load = 1'b1;  is_word = 1'b1; end
            OP_LBU:  begin is_load = 1'b1;  is_byte = 1'b1; end
            OP_LHU:  begin is_load = 1'b1;  is_half = 1'b1; end
            OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = is_mem & ((is_half & a[0]) | (is_word & (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign start = (state == IDLE) && is_mem && !misalign;

    // Big-endian lanes: address 0 is the most significant byte.
    always_comb begin
        sel     = 4'b1111;
        st_data = mem_reg2;
        if (is_byte) begin
            sel     = 4'b1000 >> a;
            st_data = {4{mem_reg2[7:0]}};
        end else if (is_half) begin
            sel     = a[1] ? 4'b0011 : 4'b1100;
            st_data = {2{mem_reg2[15:0]}};
        end
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata_q[31:24];
            2'd1:    b = rdata_q[23:16];
            2'd2:    b = rdata_q[15:8];
            default: b = rdata_q[7:0];
        endcase
        h = a[1] ? rdata_q[15:0] : rdata_q[31:16];
        if (is_byte)
            ld_data = {{24{is_signed & b[7]}}, b};
        else if (is_half)
            ld_data = {{16{is_signed & h[15]}}, h};
        else
            ld_data = rdata_q;
    end

    // The EX/MEM latch is frozen by stallreq, so mem_* still describe the op through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        abort_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        rdata_q <= dbus_rdata;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        abort_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_wd      = '0;
        wb_wreg    = 1'b0;
        wb_wdata   = '0;
        stallreq   = 1'b0;
        bus_err    = 1'b0;
        req        = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_sel   = '0;
        dbus_wdata = '0;
        // Reset gates every output so an abandoned transfer drops without a clock edge.
        if (rst) begin
            wb_wd    = mem_wd;
            wb_wdata = mem_wdata;
            case (state)
                IDLE: begin
                    if (misalign) begin
                        bus_err = 1'b1;
                    end else if (is_mem) begin
                        req      = 1'b1;
                        stallreq = 1'b1;
                    end else begin
                        wb_wreg = mem_wreg;
                    end
                end
                BUSY: begin
                    req      = 1'b1;
                    stallreq = 1'b1;
                end
                DONE: begin
                    if (abort_q) begin
                        bus_err = 1'b1;
                    end else if (is_load) begin
                        wb_wreg  = mem_wreg;
                        wb_wdata = ld_data;
                    end
                end
                default: ;
            endcase
            if (req) begin
                dbus_we    = is_store;
                dbus_addr  = {mem_mem_addr[31:2], 2'b00};
                dbus_sel   = sel;
                dbus_wdata = is_store ? st_data : 32'h0;
            end
        end
        dbus_req = req;
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver queues expected retirements and bus requests, negedge monitor checks them.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq, bus_err, dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_sel;

    mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        err;
        int          stall;
        int          req;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    exp_t sb[$];
    bus_t bq[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   retired = 0;
    int   stall_cnt = 0;
    int   req_cnt = 0;
    logic req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bus_t b;
        if (!rst) begin
            stall_cnt = 0;
            req_cnt   = 0;
            req_prev  = 1'b0;
        end else begin
            if (dbus_req && !req_prev) begin
                if (bq.size() == 0) begin
                    check("unexpected_req", 32'(dbus_req), 32'd0);
                end else begin
                    b = bq.pop_front();
                    check("bus_addr", dbus_addr, b.addr);
                    check("bus_sel", 32'(dbus_sel), 32'(b.sel));
                    check("bus_we", 32'(dbus_we), 32'(b.we));
                    if (b.we) check("bus_wdata", dbus_wdata, b.wdata);
                end
            end
            req_prev = dbus_req;
            if (dbus_req) req_cnt++;
            if (stallreq) stall_cnt++;
            if (!stallreq && sb.size() > 0) begin
                e = sb.pop_front();
                check("wb_wd", 32'(wb_wd), 32'(e.wd));
                check("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
                if (e.wreg) check("wb_wdata", wb_wdata, e.wdata);
                check("bus_err", 32'(bus_err), 32'(e.err));
                check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                check("req_cycles", 32'(req_cnt), 32'(e.req));
                stall_cnt = 0;
                req_cnt   = 0;
                retired++;
            end
        end
    end

    task automatic drive(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2);
        mem_aluop    = op;
        mem_wd       = wd;
        mem_wreg     = wreg;
        mem_wdata    = wdata;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
    endtask

    // ack_k: BUSY cycle index carrying the ack (-1 = none); stray raises ack during the op's first cycle.
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input int ack_k, input logic [31:0] rdata, input logic stray,
                         input exp_t e, input logic has_bus, input bus_t b);
        int r0;
        int n;
        @(posedge clk);
        #1;
        drive(op, e.wd, 1'b1, 32'h0000_1234, addr, reg2);
        dbus_ack   = stray;
        dbus_rdata = rdata;
        sb.push_back(e);
        if (has_bus) bq.push_back(b);
        r0 = retired;
        if (ack_k >= 0) begin
            repeat (ack_k + 1) @(posedge clk);
            #1 dbus_ack = 1'b1;
            @(posedge clk);
            #1 dbus_ack = 1'b0;
        end
        n = 0;
        while (retired == r0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (retired == r0) check("retire_timeout", 32'(retired), 32'(r0 + 1));
        dbus_ack = 1'b0;
    endtask

    localparam bus_t NOBUS = '{32'h0, 4'h0, 1'b0, 32'h0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        drive(8'hE3, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'h0000_0040, 32'h1111_1111);
        #17;
        check("rst_wb_wd", 32'(wb_wd), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_dbus_req", 32'(dbus_req), 32'd0);
        drive(8'h00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        // ALU passthrough: wb mirrors inputs in the same cycle
        @(posedge clk);
        #1;
        drive(8'h21, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
        sb.push_back('{5'd5, 1'b1, 32'h0000_1234, 1'b0, 0, 0});
        @(negedge clk);
        #1;

        issue(8'hE0, 32'h103, 32'h0, 2, 32'h1122_33F0, 1'b0,
              '{5'd7, 1'b1, 32'hFFFF_FFF0, 1'b0, 4, 4}, 1'b1, '{32'h100, 4'b0001, 1'b0, 32'h0});
        issue(8'hE9, 32'h202, 32'hCAFE_BEEF, 0, 32'h0, 1'b0,
              '{5'd8, 1'b0, 32'h0, 1'b0, 2, 2}, 1'b1, '{32'h200, 4'b0011, 1'b1, 32'hBEEF_BEEF});
        issue(8'hE5, 32'h10, 32'h0, 0, 32'h8001_7FFF, 1'b0,
              '{5'd9, 1'b1, 32'h0000_8001, 1'b0, 2, 2}, 1'b1, '{32'h10, 4'b1100, 1'b0, 32'h0});
        issue(8'hE1, 32'h12, 32'h0, 1, 32'h1234_8001, 1'b0,
              '{5'd10, 1'b1, 32'hFFFF_8001, 1'b0, 3, 3}, 1'b1, '{32'h10, 4'b0011, 1'b0, 32'h0});
        issue(8'hE4, 32'h101, 32'h0, 0, 32'h11A2_3344, 1'b0,
              '{5'd11, 1'b1, 32'h0000_00A2, 1'b0, 2, 2}, 1'b1, '{32'h100, 4'b0100, 1'b0, 32'h0});
        issue(8'hE8, 32'h3, 32'h0000_00AB, 1, 32'h0, 1'b0,
              '{5'd12, 1'b0, 32'h0, 1'b0, 3, 3}, 1'b1, '{32'h0, 4'b0001, 1'b1, 32'hABAB_ABAB});
        issue(8'hEB, 32'h8, 32'hDEAD_BEEF, 0, 32'h0, 1'b0,
              '{5'd13, 1'b0, 32'h0, 1'b0, 2, 2}, 1'b1, '{32'h8, 4'b1111, 1'b1, 32'hDEAD_BEEF});
        // Timeout: IDLE + 4 BUSY cycles of request, then abort
        issue(8'hE3, 32'h20, 32'h0, -1, 32'h0, 1'b0,
              '{5'd14, 1'b0, 32'h0, 1'b1, 5, 5}, 1'b1, '{32'h20, 4'b1111, 1'b0, 32'h0});
        // Stray ack on a non-memory op must not start anything
        issue(8'h00, 32'h0, 32'h0, -1, 32'h5555_5555, 1'b1,
              '{5'd3, 1'b1, 32'h0000_1234, 1'b0, 0, 0}, 1'b0, NOBUS);
`ifdef MEM_ALIGN_CHECK_EN
        issue(8'hE3, 32'h6, 32'h0, -1, 32'h0, 1'b0,
              '{5'd15, 1'b0, 32'h0, 1'b1, 0, 0}, 1'b0, NOBUS);
`else
        issue(8'hE3, 32'h6, 32'h0, 0, 32'h0102_0304, 1'b0,
              '{5'd15, 1'b1, 32'h0102_0304, 1'b0, 2, 2}, 1'b1, '{32'h4, 4'b1111, 1'b0, 32'h0});
`endif

        // Reset in the middle of BUSY
        @(posedge clk);
        #1;
        drive(8'hE3, 5'd16, 1'b1, 32'h0, 32'h30, 32'h0);
        bq.push_back('{32'h30, 4'b1111, 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_dbus_req", 32'(dbus_req), 32'd0);
        check("midrst_stallreq", 32'(stallreq), 32'd0);
        check("midrst_wb_wd", 32'(wb_wd), 32'd0);
        check("midrst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        drive(8'h00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        issue(8'hE3, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 1'b0,
              '{5'd17, 1'b1, 32'hCAFE_F00D, 1'b0, 2, 2}, 1'b1, '{32'h40, 4'b1111, 1'b0, 32'h0});

        drive(8'h00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_left", 32'(sb.size()), 32'd0);
        check("bus_left", 32'(bq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
